// File: rtl/parking_slot_allocator.sv
// ---------------------------------------------------------------------------
// parking_slot_allocator
//   Entry-side slot allocator. On an entry request it offers the lowest-index
//   free slot (one-hot), marks it occupied when the gate acknowledges, and
//   clears slots on exit events. Holds the registered occupancy bitmap, the
//   free-slot count and the full flag.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   load_valid/map    one-cycle overwrite of the occupancy bitmap (1=occupied)
//   entry_req         level request from the entry gate (4-phase handshake)
//   grant_valid/loc   current slot offer (location is zero when not offering)
//   entry_ack         gate accepts the offer, only looked at during an offer
//   exit_valid/loc    one-cycle pulse: car left the one-hot exit_location
//   exit_error        one-cycle pulse after a rejected exit
//   occupancy         registered bitmap
//   free_count, full  registered, derived from the same next-state bitmap
// ---------------------------------------------------------------------------
module parking_slot_allocator #(
   parameter int SLOTS = 8,
   parameter int CW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   input  logic [SLOTS-1:0] load_map,
   input  logic             entry_req,
   output logic             grant_valid,
   output logic [SLOTS-1:0] grant_location,
   input  logic             entry_ack,
   output logic             full,
   input  logic             exit_valid,
   input  logic [SLOTS-1:0] exit_location,
   output logic             exit_error,
   output logic [SLOTS-1:0] occupancy,
   output logic [CW-1:0]    free_count
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_OFFER   = 2'd1;
   localparam logic [1:0] S_RELEASE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             grant_valid_q, grant_valid_d;
   logic [SLOTS-1:0] grant_location_q, grant_location_d;
   logic [SLOTS-1:0] occupancy_q, occupancy_d;
   logic [CW-1:0]    free_count_q, free_count_d;
   logic             full_q, full_d;
   logic             exit_error_q, exit_error_d;

   logic [SLOTS-1:0] free_map;
   logic [SLOTS-1:0] lowest_free;
   logic             exit_onehot;
   logic             exit_ok;
   logic             ack_fire;
   logic [CW-1:0]    occ_cnt;

   // Isolate the lowest set bit of the free map: x & -x.
   assign free_map    = ~occupancy_q;
   assign lowest_free = free_map & (~free_map + SLOTS'(1));

   assign exit_onehot = (exit_location != '0) &&
                        ((exit_location & (exit_location - SLOTS'(1))) == '0);
   // The offered slot is still free in occupancy_q, so an exit naming it
   // fails the occupied test and is rejected here without a special case.
   assign exit_ok     = exit_valid && exit_onehot && ((exit_location & occupancy_q) != '0);
   assign ack_fire    = (state_q == S_OFFER) && entry_ack;

   // Bitmap update: a load overrides both the ack's set and the exit's clear.
   always_comb begin
      occupancy_d = occupancy_q;
      if (load_valid) begin
         occupancy_d = load_map;
      end else begin
         if (ack_fire) occupancy_d = occupancy_d | grant_location_q;
         if (exit_ok)  occupancy_d = occupancy_d & ~exit_location;
      end
      exit_error_d = exit_valid && !exit_ok && !load_valid;
   end

   // Count and full flag come from the next-state bitmap so they always
   // match occupancy in the same cycle.
   always_comb begin
      occ_cnt = '0;
      for (int i = 0; i < SLOTS; i++) begin
         occ_cnt = occ_cnt + CW'(occupancy_d[i]);
      end
      free_count_d = CW'(SLOTS) - occ_cnt;
      full_d       = &occupancy_d;
   end

   always_comb begin
      state_d          = state_q;
      grant_valid_d    = grant_valid_q;
      grant_location_d = grant_location_q;
      case (state_q)
         S_IDLE: begin
            if (entry_req && !full_q) begin
               state_d          = S_OFFER;
               grant_valid_d    = 1'b1;
               grant_location_d = lowest_free;
            end
         end
         S_OFFER: begin
            // Offer stays frozen; no re-search while it is outstanding.
            if (entry_ack) begin
               state_d          = S_RELEASE;
               grant_valid_d    = 1'b0;
               grant_location_d = '0;
            end else if (!entry_req ||
                         (load_valid && ((load_map & grant_location_q) != '0))) begin
               // Withdrawn by the gate, or the slot was taken by a sensor load.
               state_d          = S_IDLE;
               grant_valid_d    = 1'b0;
               grant_location_d = '0;
            end
         end
         S_RELEASE: begin
            if (!entry_req) state_d = S_IDLE;
         end
         default: begin
            state_d          = S_IDLE;
            grant_valid_d    = 1'b0;
            grant_location_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= S_IDLE;
         grant_valid_q    <= 1'b0;
         grant_location_q <= '0;
         occupancy_q      <= '0;
         free_count_q     <= CW'(SLOTS);
         full_q           <= 1'b0;
         exit_error_q     <= 1'b0;
      end else begin
         state_q          <= state_d;
         grant_valid_q    <= grant_valid_d;
         grant_location_q <= grant_location_d;
         occupancy_q      <= occupancy_d;
         free_count_q     <= free_count_d;
         full_q           <= full_d;
         exit_error_q     <= exit_error_d;
      end
   end

   assign grant_valid    = grant_valid_q;
   assign grant_location = grant_location_q;
   assign occupancy      = occupancy_q;
   assign free_count     = free_count_q;
   assign full           = full_q;
   assign exit_error     = exit_error_q;

endmodule

// File: tb/tb_parking_slot_allocator.sv
// ---------------------------------------------------------------------------
// tb_parking_slot_allocator
//   Table of {inputs, expected outputs after the next edge} records applied
//   one per cycle through a scoreboard queue, plus hand-written sequences for
//   the async reset during an offer.
// ---------------------------------------------------------------------------
module tb_parking_slot_allocator;

   localparam int SLOTS = 8;
   localparam int CW    = 4;

   logic             clk;
   logic             rst_n;
   logic             load_valid;
   logic [SLOTS-1:0] load_map;
   logic             entry_req;
   logic             grant_valid;
   logic [SLOTS-1:0] grant_location;
   logic             entry_ack;
   logic             full;
   logic             exit_valid;
   logic [SLOTS-1:0] exit_location;
   logic             exit_error;
   logic [SLOTS-1:0] occupancy;
   logic [CW-1:0]    free_count;

   parking_slot_allocator #(.SLOTS(SLOTS), .CW(CW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .load_valid    (load_valid),
      .load_map      (load_map),
      .entry_req     (entry_req),
      .grant_valid   (grant_valid),
      .grant_location(grant_location),
      .entry_ack     (entry_ack),
      .full          (full),
      .exit_valid    (exit_valid),
      .exit_location (exit_location),
      .exit_error    (exit_error),
      .occupancy     (occupancy),
      .free_count    (free_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       gv;
      logic [7:0] gloc;
      logic [7:0] occ;
      logic [3:0] fc;
      logic       full;
      logic       err;
   } exp_t;

   typedef struct {
      string      name;
      logic       lv;
      logic [7:0] lmap;
      logic       req;
      logic       ack;
      logic       ev;
      logic [7:0] eloc;
      exp_t       exp;
   } vec_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic exp_t mk_exp(logic gv, logic [7:0] gloc, logic [7:0] occ,
                                   logic [3:0] fc, logic fl, logic err);
      exp_t e;
      e.gv = gv; e.gloc = gloc; e.occ = occ; e.fc = fc; e.full = fl; e.err = err;
      return e;
   endfunction

   function automatic void add(string nm, logic lv, logic [7:0] lmap, logic req,
                               logic ack, logic ev, logic [7:0] eloc, exp_t e);
      vec_t v;
      v.name = nm; v.lv = lv; v.lmap = lmap; v.req = req; v.ack = ack;
      v.ev = ev; v.eloc = eloc; v.exp = e;
      vecs.push_back(v);
   endfunction

   task automatic chk(string nm, int act, int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(string nm, exp_t e);
      chk({nm, ".grant_valid"},    int'(grant_valid),    int'(e.gv));
      chk({nm, ".grant_location"}, int'(grant_location), int'(e.gloc));
      chk({nm, ".occupancy"},      int'(occupancy),      int'(e.occ));
      chk({nm, ".free_count"},     int'(free_count),     int'(e.fc));
      chk({nm, ".full"},           int'(full),           int'(e.full));
      chk({nm, ".exit_error"},     int'(exit_error),     int'(e.err));
   endtask

   // Drive one record, push its expectation, let one edge pass, compare.
   task automatic apply(vec_t v);
      exp_t e;
      load_valid    = v.lv;
      load_map      = v.lmap;
      entry_req     = v.req;
      entry_ack     = v.ack;
      exit_valid    = v.ev;
      exit_location = v.eloc;
      sb_q.push_back(v.exp);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk_all(v.name, e);
   endtask

   task automatic idle_inputs();
      load_valid = 0; load_map = '0; entry_req = 0; entry_ack = 0;
      exit_valid = 0; exit_location = '0;
   endtask

   initial begin
      vec_t v;
      exp_t rst_e;
      bit   seen;
      rst_e = mk_exp(0, 8'h00, 8'h00, 4'd8, 0, 0);

      // ------------------------------------------------------------ table
      //   name          lv lmap   rq ak ev eloc    gv gloc   occ    fc  fl er
      add("first_offer",  0, 8'h00, 1, 0, 0, 8'h00, mk_exp(1, 8'h01, 8'h00, 4'd8, 0, 0));
      add("first_ack",    0, 8'h00, 1, 1, 0, 8'h00, mk_exp(0, 8'h00, 8'h01, 4'd7, 0, 0));
      add("held_req",     0, 8'h00, 1, 0, 0, 8'h00, mk_exp(0, 8'h00, 8'h01, 4'd7, 0, 0));
      add("req_drop",     0, 8'h00, 0, 0, 0, 8'h00, mk_exp(0, 8'h00, 8'h01, 4'd7, 0, 0));
      add("load_55",      1, 8'h55, 0, 0, 0, 8'h00, mk_exp(0, 8'h00, 8'h55, 4'd4, 0, 0));
      add("offer_slot1",  0, 8'h00, 1, 0, 0, 8'h00, mk_exp(1, 8'h02, 8'h55, 4'd4, 0, 0));
      add("ack_slot1",    0, 8'h00, 1, 1, 0, 8'h00, mk_exp(0, 8'h00, 8'h57, 4'd3, 0, 0));
      add("req_drop2",    0, 8'h00, 0, 0, 0, 8'h00, mk_exp(0, 8'h00, 8'h57, 4'd3, 0, 0));
      add("exit_ok",      0, 8'h00, 0, 0, 1, 8'h04, mk_exp(0, 8'h00, 8'h53, 4'd4, 0, 0));
      add("exit_free",    0, 8'h00, 0, 0, 1, 8'h08, mk_exp(0, 8'h00, 8'h53, 4'd4, 0, 1));
      add("err_clears",   0, 8'h00, 0, 0, 0, 8'h00, mk_exp(0, 8'h00, 8'h53, 4'd4, 0, 0));
      add("exit_multi",   0, 8'h00, 0, 0, 1, 8'h03, mk_exp(0, 8'h00, 8'h53, 4'd4, 0, 1));
      add("idle_a",       0, 8'h00, 0, 0, 0, 8'h00, mk_exp(0, 8'h00, 8'h53, 4'd4, 0, 0));
      add("exit_zero",    0, 8'h00, 0, 0, 1, 8'h00, mk_exp(0, 8'h00, 8'h53, 4'd4, 0, 1));
      add("load_ff",      1, 8'hFF, 0, 0, 0, 8'h00, mk_exp(0, 8'h00, 8'hFF, 4'd0, 1, 0));
      for (int i = 0; i < 5; i++)
         add("full_req",  0, 8'h00, 1, 0, 0, 8'h00, mk_exp(0, 8'h00, 8'hFF, 4'd0, 1, 0));
      add("full_drop",    0, 8'h00, 0, 0, 0, 8'h00, mk_exp(0, 8'h00, 8'hFF, 4'd0, 1, 0));
      add("load_07",      1, 8'h07, 0, 0, 0, 8'h00, mk_exp(0, 8'h00, 8'h07, 4'd5, 0, 0));
      add("offer_slot3",  0, 8'h00, 1, 0, 0, 8'h00, mk_exp(1, 8'h08, 8'h07, 4'd5, 0, 0));
      add("ack_and_exit", 0, 8'h00, 1, 1, 1, 8'h01, mk_exp(0, 8'h00, 8'h0E, 4'd5, 0, 0));
      add("req_drop3",    0, 8'h00, 0, 0, 0, 8'h00, mk_exp(0, 8'h00, 8'h0E, 4'd5, 0, 0));
      add("offer_slot0",  0, 8'h00, 1, 0, 0, 8'h00, mk_exp(1, 8'h01, 8'h0E, 4'd5, 0, 0));
      add("exit_offered", 0, 8'h00, 1, 0, 1, 8'h01, mk_exp(1, 8'h01, 8'h0E, 4'd5, 0, 1));
      add("withdraw",     0, 8'h00, 0, 0, 0, 8'h00, mk_exp(0, 8'h00, 8'h0E, 4'd5, 0, 0));
      add("offer_again",  0, 8'h00, 1, 0, 0, 8'h00, mk_exp(1, 8'h01, 8'h0E, 4'd5, 0, 0));
      add("load_takes",   1, 8'h0F, 1, 0, 0, 8'h00, mk_exp(0, 8'h00, 8'h0F, 4'd4, 0, 0));
      add("reoffer",      0, 8'h00, 1, 0, 0, 8'h00, mk_exp(1, 8'h10, 8'h0F, 4'd4, 0, 0));
      add("ack_vs_load",  1, 8'h00, 1, 1, 0, 8'h00, mk_exp(0, 8'h00, 8'h00, 4'd8, 0, 0));
      add("release_held", 0, 8'h00, 1, 0, 0, 8'h00, mk_exp(0, 8'h00, 8'h00, 4'd8, 0, 0));
      add("req_drop4",    0, 8'h00, 0, 0, 0, 8'h00, mk_exp(0, 8'h00, 8'h00, 4'd8, 0, 0));
      add("offer_s0",     0, 8'h00, 1, 0, 0, 8'h00, mk_exp(1, 8'h01, 8'h00, 4'd8, 0, 0));
      add("load_keeps",   1, 8'h80, 1, 0, 0, 8'h00, mk_exp(1, 8'h01, 8'h80, 4'd7, 0, 0));
      add("ack_after_ld", 0, 8'h00, 1, 1, 0, 8'h00, mk_exp(0, 8'h00, 8'h81, 4'd6, 0, 0));
      add("req_drop5",    0, 8'h00, 0, 0, 0, 8'h00, mk_exp(0, 8'h00, 8'h81, 4'd6, 0, 0));
      add("load_vs_exit", 1, 8'h00, 0, 0, 1, 8'h03, mk_exp(0, 8'h00, 8'h00, 4'd8, 0, 0));

      // ------------------------------------------------------------ reset
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", rst_e);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) apply(vecs[i]);

      // ---------------- async reset during an offer discards it
      v = vecs[0];
      v.name = "pre_load"; v.lv = 1; v.lmap = 8'h03; v.req = 0;
      v.exp = mk_exp(0, 8'h00, 8'h03, 4'd6, 0, 0);
      apply(v);
      idle_inputs();
      entry_req = 1'b1;
      seen = 0;
      for (int c = 0; c < 5 && !seen; c++) begin
         @(posedge clk);
         #1;
         seen = grant_valid;
      end
      chk("offer_before_reset.seen", int'(seen), 1);
      chk("offer_before_reset.gloc", int'(grant_location), 8'h04);
      #2;
      rst_n = 1'b0;          // mid-cycle, no clock edge involved
      #1;
      chk_all("async_reset", rst_e);
      entry_req = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      v.name = "post_reset_offer"; v.lv = 0; v.lmap = 8'h00; v.req = 1;
      v.exp = mk_exp(1, 8'h01, 8'h00, 4'd8, 0, 0);
      apply(v);
      v.name = "post_reset_withdraw"; v.req = 0;
      v.exp = mk_exp(0, 8'h00, 8'h00, 4'd8, 0, 0);
      apply(v);

      chk("scoreboard_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
